// File: rtl/tt_sweep_ctrl.sv
// Purpose: walks a 4-input combinational block through all 16 input codes, captures F into a truth table and compares it with an expected table.
// Latency: done pulses 16*SETTLE_CYCLES+1 cycles after the accepted start (earlier on a mismatch when STOP_ON_MISMATCH_EN is defined).
// Backpressure: none; start is honoured only in IDLE, and starts seen while busy or in DONE are dropped.
module tt_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_out,
    output logic        mism_valid,
    output logic [3:0]  mism_idx,
    output logic [4:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [7:0]  cnt;
    logic [15:0] exp_q;
    logic        sample;
    logic        mism;
    logic        last;

    // The function block sees the current vector index directly from a register.
    assign {a, b, c, d} = idx;

    // F is taken on the final settle cycle of each vector.
    assign sample = (state == RUN) && (cnt == CNT_LAST);
    assign mism   = sample && (f_in != exp_q[idx]);

`ifdef STOP_ON_MISMATCH_EN
    // Sweep ends after vector 15 or at the first disagreeing sample.
    assign last = sample && ((idx == 4'hF) || mism);
`else
    // Sweep always covers all 16 vectors.
    assign last = sample && (idx == 4'hF);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector stepping, capture and compare bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= 4'd0;
            cnt        <= 8'd0;
            exp_q      <= 16'd0;
            table_out  <= 16'd0;
            pass       <= 1'b0;
            mism_valid <= 1'b0;
            mism_idx   <= 4'd0;
            err_count  <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q      <= expected;
                        table_out  <= 16'd0;
                        pass       <= 1'b0;
                        mism_valid <= 1'b0;
                        mism_idx   <= 4'd0;
                        err_count  <= 5'd0;
                        idx        <= 4'd0;
                        cnt        <= 8'd0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        table_out[idx] <= f_in;
                        if (mism) begin
                            err_count <= err_count + 5'd1;
                            if (!mism_valid) begin
                                mism_valid <= 1'b1;
                                mism_idx   <= idx;
                            end
                        end
                        if (last) begin
                            // Fold in the compare of the final sample so pass is right during done.
                            pass <= (err_count == 5'd0) && !mism;
                        end else begin
                            idx <= idx + 4'd1;
                            cnt <= 8'd0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: one instance with SETTLE_CYCLES=1 driving a model function block,
// one with SETTLE_CYCLES=3 and F tied high; directed vectors with hand-computed results.
// Expectations follow STOP_ON_MISMATCH_EN when it is defined.
module tb_tt_sweep_ctrl;

`ifdef STOP_ON_MISMATCH_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start1, start3;
    logic [15:0] exp1, exp3;
    logic        f1;
    logic        a1, b1, c1, d1, busy1, done1, pass1, mv1;
    logic [15:0] tab1;
    logic [3:0]  midx1;
    logic [4:0]  err1;
    logic        a3, b3, c3, d3, busy3, done3, pass3, mv3;
    logic [15:0] tab3;
    logic [3:0]  midx3;
    logic [4:0]  err3;

    tt_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .f_in(f1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
        .table_out(tab1), .mism_valid(mv1), .mism_idx(midx1), .err_count(err1)
    );

    tt_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .f_in(1'b1),
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .pass(pass3),
        .table_out(tab3), .mism_valid(mv3), .mism_idx(midx3), .err_count(err3)
    );

    // Function block: F = ~A (CD=00), B (01), ~B (10), 0 (11).
    always_comb begin
        case ({c1, d1})
            2'b00:   f1 = ~a1;
            2'b01:   f1 = b1;
            2'b10:   f1 = ~b1;
            default: f1 = 1'b0;
        endcase
    end

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Pulse start on dut1 and return the cycle (1 = first cycle after the start edge) where done is seen.
    task automatic sweep1(input logic [15:0] e, output int done_cyc, output int busy_n);
        exp1   = e;
        start1 = 1'b1;
        @(negedge clk);
        start1   = 1'b0;
        done_cyc = -1;
        busy_n   = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (busy1) busy_n++;
            if (done1) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [15:0] expd;
        logic [15:0] tab;
        logic        pass;
        logic        mv;
        logic [3:0]  midx;
        logic [4:0]  err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          dc, bn, e_dc, e_bn, steps_ok, dcount, first_done, d1st, d2nd, L;
        logic [15:0] e_tab;
        logic [4:0]  e_err;
        logic [16:0] m;

        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        exp1   = 16'h0;
        exp3   = 16'h0;
        repeat (3) @(negedge clk);

        chk("rst_busy",  busy1, 0);
        chk("rst_done",  done1, 0);
        chk("rst_pass",  pass1, 0);
        chk("rst_tab",   tab1, 0);
        chk("rst_mv",    mv1, 0);
        chk("rst_midx",  midx1, 0);
        chk("rst_err",   err1, 0);
        chk("rst_abcd",  {a1, b1, c1, d1}, 0);
        chk("rst3_busy", busy3, 0);
        chk("rst3_tab",  tab3, 0);
        rst_n = 1'b1;
        @(negedge clk);

        //          expected  table     pass  mv    midx   err
        vecs[0] = '{16'h2435, 16'h2435, 1'b1, 1'b0, 4'd0,  5'd0};
        vecs[1] = '{16'h2437, 16'h2435, 1'b0, 1'b1, 4'd1,  5'd1};
        vecs[2] = '{16'hDBCA, 16'h2435, 1'b0, 1'b1, 4'd0,  5'd16};
        vecs[3] = '{16'h2434, 16'h2435, 1'b0, 1'b1, 4'd0,  5'd1};
        vecs[4] = '{16'hA435, 16'h2435, 1'b0, 1'b1, 4'd15, 5'd1};
        vecs[5] = '{16'h3535, 16'h2435, 1'b0, 1'b1, 4'd8,  5'd2};

        for (int i = 0; i < 6; i++) begin
            sweep1(vecs[i].expd, dc, bn);
            e_tab = vecs[i].tab;
            e_err = vecs[i].err;
            e_dc  = 17;
            e_bn  = 16;
            if (STOP && vecs[i].mv) begin
                m     = (17'd2 << vecs[i].midx) - 17'd1;
                e_tab = vecs[i].tab & m[15:0];
                e_err = 5'd1;
                e_dc  = int'(vecs[i].midx) + 2;
                e_bn  = int'(vecs[i].midx) + 1;
            end
            chk($sformatf("v%0d_done_cyc", i), dc, e_dc);
            chk($sformatf("v%0d_busy_cnt", i), bn, e_bn);
            chk($sformatf("v%0d_tab", i),  tab1, e_tab);
            chk($sformatf("v%0d_pass", i), pass1, vecs[i].pass);
            chk($sformatf("v%0d_mv", i),   mv1, vecs[i].mv);
            chk($sformatf("v%0d_midx", i), midx1, vecs[i].midx);
            chk($sformatf("v%0d_err", i),  err1, e_err);
            @(negedge clk);
            chk($sformatf("v%0d_done_low", i), {done1, busy1}, 0);
            chk($sformatf("v%0d_tab_hold", i), tab1, e_tab);
        end

        // Starts during a sweep are ignored; a..d step one code per cycle.
        exp1   = 16'h2435;
        start1 = 1'b1;
        @(negedge clk);
        start1     = 1'b0;
        steps_ok   = 0;
        dcount     = 0;
        first_done = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc <= 16 && {a1, b1, c1, d1} == 4'(cyc - 1)) steps_ok++;
            if (done1) begin
                dcount++;
                if (first_done < 0) first_done = cyc;
            end
            start1 = (cyc == 5 || cyc == 10);
            @(negedge clk);
        end
        start1 = 1'b0;
        chk("ign_steps",     steps_ok, 16);
        chk("ign_done_cnt",  dcount, 1);
        chk("ign_done_cyc",  first_done, 17);
        chk("ign_pass",      pass1, 1);

        // Reset in cycle 8 of a sweep.
        exp1   = 16'h2435;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) @(negedge clk);
        chk("pre_rst_busy", busy1, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_done", done1, 0);
        chk("mid_rst_tab",  tab1, 0);
        chk("mid_rst_abcd", {a1, b1, c1, d1}, 0);
        chk("mid_rst_misc", {pass1, mv1, midx1, err1}, 0);
        rst_n  = 1'b1;
        dcount = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done1 || busy1) dcount++;
            @(negedge clk);
        end
        chk("post_rst_quiet", dcount, 0);
        sweep1(16'h2435, dc, bn);
        chk("post_rst_done_cyc", dc, 17);
        chk("post_rst_tab",      tab1, 16'h2435);
        chk("post_rst_pass",     pass1, 1);
        @(negedge clk);

        // SETTLE_CYCLES=3, F tied high, expected all zeros.
        exp3   = 16'h0000;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        dc = -1;
        bn = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (busy3) bn++;
            if (done3) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("s3_done_cyc", dc, STOP ? 4 : 49);
        chk("s3_busy_cnt", bn, STOP ? 3 : 48);
        chk("s3_tab",      tab3, STOP ? 16'h0001 : 16'hFFFF);
        chk("s3_err",      err3, STOP ? 1 : 16);
        chk("s3_midx",     midx3, 0);
        chk("s3_mv",       mv3, 1);
        chk("s3_pass",     pass3, 0);

        // start held high: back-to-back sweeps, results cleared at each accepted start.
        L      = STOP ? 3 : 17;
        exp1   = 16'h2437;
        start1 = 1'b1;
        @(negedge clk);
        d1st = -1;
        d2nd = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done1) begin
                if (d1st < 0) d1st = cyc;
                else if (d2nd < 0) d2nd = cyc;
            end
            if (cyc == L + 2) begin
                chk("held_clr_tab",  tab1, 0);
                chk("held_clr_err",  err1, 0);
                chk("held_clr_mv",   mv1, 0);
                chk("held_clr_busy", busy1, 1);
            end
            @(negedge clk);
        end
        start1 = 1'b0;
        chk("held_done1", d1st, L);
        chk("held_done2", d2nd, 2 * L + 1);

        dcount = 0;
        while ((busy1 || done1) && dcount < 100) begin
            dcount++;
            @(negedge clk);
        end
        chk("drain_idle", {busy1, done1}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
